dcpu16_mem_resp: RTL and testbench
==================================

// Module: dcpu16_mem_resp
// PURPOSE
// - Responder (slave) for the CPU's two memory-bus initiators: FBUS (fs_*) and ABUS (ab_*).
// - Serves both ports from one shared single-port word RAM, with round-robin arbitration,
//   programmable wait states and a registered one-cycle ack per transfer.
// - Sits outside the CPU core; it is the memory model used in system integration and benches.
// PARAMETERS
// - AW     12       RAM address bits; depth 2**AW words; adr[15:AW] ignored (aliasing)
// - WAIT   0        extra wait cycles between grant and ack (0..15)
// - PTOP   16'h0200 with DCPU16_MEM_WPROT_EN: words at adr < PTOP are write-protected
// PORTS
// - clk     in   1   clock, all logic on rising edge
// - rst     in   1   synchronous, active-high reset
// - fs_adr  in  16   FBUS word address
// - fs_stb  in   1   FBUS request strobe, held by initiator until fs_ack
// - fs_wre  in   1   FBUS write enable (1 write, 0 read), qualified by fs_stb
// - fs_dto  in  16   FBUS write data (initiator to memory)
// - fs_dti  out 16   FBUS read data (memory to initiator), valid while fs_ack=1
// - fs_ack  out  1   FBUS transfer-complete pulse
// - ab_adr, ab_stb, ab_wre, ab_dto, ab_dti, ab_ack: as fs_*, for ABUS
// - wp_err  out  1   sticky flag: a write hit the protected region
// BEHAVIOUR
// - Reset: state=IDLE, fs_ack=ab_ack=0, fs_dti=ab_dti=16'h0000, wp_err=0, last=AB
//   (FS wins the first tie). RAM contents are not reset.
// - FSM states: IDLE, WAIT, ACK. All outputs are registered.
// - IDLE: if no stb, stay. If exactly one stb, grant that port. If both, grant the port
//   that was not served last (round-robin). On grant, latch port, adr[AW-1:0], wre and dto.
//   - If WAIT=0, go to ACK.
//   - If WAIT>0, load cnt=WAIT-1 and go to WAIT.
// - WAIT: decrement cnt; go to ACK when cnt=0. The latched request is used;
//   initiator signal changes are ignored.
// - RAM access happens on the edge entering ACK:
//   - write: mem[adr] <= dto.
//   - read: granted-port dti <= mem[adr].
//   - Granted-port ack <= 1; last <= granted port.
// - ACK: ack is high for exactly one cycle; no new grant is made in ACK.
//   This guards against re-serving a stb the initiator still holds during ack.
//   Next state: IDLE; ack <= 0.
// - Latency: stb sampled at edge N -> ack high in cycle N+1+WAIT.
//   Maximum throughput: one transfer per 2+WAIT cycles.
// - dti holds its last read value after ack and is updated only by reads on that port;
//   writes leave dti unchanged.
// - fs_ack and ab_ack are never high in the same cycle.
// - A stb deasserted before its ack is a protocol violation; the latched transfer still completes.
// - Simultaneous stb in IDLE with both ports alternating: strict FS,AB,FS,AB service order.
// - Reset mid-transfer (in WAIT or ACK): return to IDLE, ack forced 0 next cycle.
//   - A write not yet committed (still in WAIT) is dropped.
//   - A write already committed stays in RAM.
// - Address wrap: adr 16'hFFFF maps to word 2**AW-1; adr 2**AW aliases word 0.
// CONFIGURATION
// - DCPU16_MEM_WPROT_EN defined: writes with adr[15:0] < PTOP are acked normally, RAM is
//   not modified, and wp_err is set to 1, sticky until rst. Reads are unaffected.
// - Undefined: all addresses writable; wp_err tied 0; PTOP unused.
// TESTING
// - Reset, then FS read of adr 0 with RAM preloaded 16'h7C01, WAIT=0
//   -> fs_ack pulses 1 cycle after stb sampled, fs_dti=16'h7C01, ab_ack=0.
// - AB write 16'hBEEF to 16'h1000, then AB read of 16'h1000, WAIT=3
//   -> each ack 4 cycles after stb; read returns 16'hBEEF; fs_dti unchanged.
// - FS and AB stb together, held across 4 transfers
//   -> service order FS,AB,FS,AB; acks never overlap; 2 cycles per transfer.
// - Initiator holds stb through its ack cycle
//   -> exactly one ack per request; no duplicate write observed.
// - WPROT_EN, PTOP=16'h0200: write 16'h1234 to 16'h0010 -> ack, RAM unchanged,
//   wp_err=1 until rst. Write to 16'h0200 -> succeeds.
// - rst asserted in WAIT (WAIT=5) during write of 16'hAAAA to 16'h0300
//   -> no ack; RAM[0x300] keeps its old value; FSM in IDLE.

Source files
------------

// File: rtl/dcpu16_mem_resp.sv
// dcpu16_mem_resp: FBUS/ABUS responder over one shared single-port word RAM, with round-robin
// arbitration, WAIT extra cycles and a registered one-cycle ack. DCPU16_MEM_WPROT_EN adds write protection below PTOP.
module dcpu16_mem_resp #(
    parameter int          AW   = 12,
    parameter int          WAIT = 0,
    parameter logic [15:0] PTOP = 16'h0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] fs_adr,
    input  logic        fs_stb,
    input  logic        fs_wre,
    input  logic [15:0] fs_dto,
    output logic [15:0] fs_dti,
    output logic        fs_ack,
    input  logic [15:0] ab_adr,
    input  logic        ab_stb,
    input  logic        ab_wre,
    input  logic [15:0] ab_dto,
    output logic [15:0] ab_dti,
    output logic        ab_ack,
    output logic        wp_err
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << AW;
    localparam bit         NO_WAIT  = (WAIT == 32'sd0);
    localparam logic [3:0] CNT_INIT = (WAIT > 32'sd0) ? 4'(WAIT - 32'sd1) : 4'd0;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [3:0]      cnt_r;
    logic [3:0]      cnt_nxt_s;
    logic            req_ab_r;
    logic [AW-1:0]   adr_r;
    logic            wre_r;
    logic [15:0]     dto_r;
    logic            last_ab_r;
    logic            fs_ack_r;
    logic            ab_ack_r;
    logic [15:0]     fs_dti_r;
    logic [15:0]     ab_dti_r;
    logic [15:0]     mem_r [DEPTH];

    logic            pick_ab_s;
    logic            grant_s;
    logic            commit_s;
    logic            req_ab_s;
    logic [AW-1:0]   req_adr_s;
    logic            req_wre_s;
    logic [15:0]     req_dto_s;
    logic            wp_blk_s;
    logic            unused_s;

    // High address bits only alias; they feed nothing in the unprotected build.
    assign unused_s = ^{fs_adr, ab_adr};

    // Round-robin pick: AB wins when FS is idle or FS was the port served last
    always_comb begin
        pick_ab_s = 1'b0;
        if (ab_stb && (!fs_stb || !last_ab_r)) begin
            pick_ab_s = 1'b1;
        end else begin
            pick_ab_s = 1'b0;
        end
    end

    // Request seen at the commit edge: live pick in IDLE (zero-wait path), latched copy otherwise
    always_comb begin
        req_ab_s  = req_ab_r;
        req_adr_s = adr_r;
        req_wre_s = wre_r;
        req_dto_s = dto_r;
        if (state_r == ST_IDLE) begin
            req_ab_s = pick_ab_s;
            if (pick_ab_s) begin
                req_adr_s = ab_adr[AW-1:0];
                req_wre_s = ab_wre;
                req_dto_s = ab_dto;
            end else begin
                req_adr_s = fs_adr[AW-1:0];
                req_wre_s = fs_wre;
                req_dto_s = fs_dto;
            end
        end else begin
            req_ab_s = req_ab_r;
        end
    end

    // Next-state logic; ACK never grants so a still-held strobe is not served twice
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        grant_s     = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fs_stb || ab_stb) begin
                    grant_s = 1'b1;
                    if (NO_WAIT) begin
                        state_nxt_s = ST_ACK;
                        commit_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = CNT_INIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_ACK;
                    commit_s    = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, latched request, acks and per-port read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            req_ab_r  <= 1'b0;
            adr_r     <= '0;
            wre_r     <= 1'b0;
            dto_r     <= 16'h0000;
            last_ab_r <= 1'b1;
            fs_ack_r  <= 1'b0;
            ab_ack_r  <= 1'b0;
            fs_dti_r  <= 16'h0000;
            ab_dti_r  <= 16'h0000;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            fs_ack_r <= commit_s && !req_ab_s;
            ab_ack_r <= commit_s && req_ab_s;
            if (grant_s) begin
                req_ab_r <= req_ab_s;
                adr_r    <= req_adr_s;
                wre_r    <= req_wre_s;
                dto_r    <= req_dto_s;
            end
            if (commit_s) begin
                last_ab_r <= req_ab_s;
                if (!req_wre_s) begin
                    if (req_ab_s) begin
                        ab_dti_r <= mem_r[req_adr_s];
                    end else begin
                        fs_dti_r <= mem_r[req_adr_s];
                    end
                end
            end
        end
    end

    // RAM write port; contents survive reset, but a write still pending at reset is dropped
    always_ff @(posedge clk) begin
        if (!rst && commit_s && req_wre_s && !wp_blk_s) begin
            mem_r[req_adr_s] <= req_dto_s;
        end
    end

`ifdef DCPU16_MEM_WPROT_EN
    logic wp_live_s;
    logic wp_r;
    logic wp_err_r;

    // Protection uses the full 16-bit address, so aliases above PTOP stay writable
    always_comb begin
        wp_live_s = 1'b0;
        if (pick_ab_s) begin
            wp_live_s = ab_wre && (ab_adr < PTOP);
        end else begin
            wp_live_s = fs_wre && (fs_adr < PTOP);
        end
    end

    assign wp_blk_s = (state_r == ST_IDLE) ? wp_live_s : wp_r;

    // Latched protection hit for waited transfers and the sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_r     <= 1'b0;
            wp_err_r <= 1'b0;
        end else begin
            if (grant_s) begin
                wp_r <= wp_live_s;
            end
            if (commit_s && wp_blk_s) begin
                wp_err_r <= 1'b1;
            end
        end
    end

    assign wp_err = wp_err_r;
`else
    assign wp_blk_s = 1'b0;
    assign wp_err   = 1'b0;
`endif

    assign fs_ack = fs_ack_r;
    assign ab_ack = ab_ack_r;
    assign fs_dti = fs_dti_r;
    assign ab_dti = ab_dti_r;

endmodule

// File: tb/tb_dcpu16_mem_resp.sv
// Directed bench for dcpu16_mem_resp: three instances with WAIT = 0, 3 and 5.
module tb_dcpu16_mem_resp;
    logic             clk = 1'b0;
    logic [2:0]       rst;
    logic [2:0]       fs_stb, fs_wre, fs_ack, ab_stb, ab_wre, ab_ack, wp_err;
    logic [2:0][15:0] fs_adr, fs_dto, fs_dti, ab_adr, ab_dto, ab_dti;

    int checks = 0;
    int errors = 0;

`ifdef DCPU16_MEM_WPROT_EN
    localparam logic [15:0] T1_ADR = 16'h0400;
`else
    localparam logic [15:0] T1_ADR = 16'h0000;
`endif

    always #5 clk = ~clk;

    dcpu16_mem_resp #(.AW(12), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst[0]),
        .fs_adr(fs_adr[0]), .fs_stb(fs_stb[0]), .fs_wre(fs_wre[0]), .fs_dto(fs_dto[0]),
        .fs_dti(fs_dti[0]), .fs_ack(fs_ack[0]),
        .ab_adr(ab_adr[0]), .ab_stb(ab_stb[0]), .ab_wre(ab_wre[0]), .ab_dto(ab_dto[0]),
        .ab_dti(ab_dti[0]), .ab_ack(ab_ack[0]), .wp_err(wp_err[0]));

    dcpu16_mem_resp #(.AW(12), .WAIT(3)) u_w3 (
        .clk(clk), .rst(rst[1]),
        .fs_adr(fs_adr[1]), .fs_stb(fs_stb[1]), .fs_wre(fs_wre[1]), .fs_dto(fs_dto[1]),
        .fs_dti(fs_dti[1]), .fs_ack(fs_ack[1]),
        .ab_adr(ab_adr[1]), .ab_stb(ab_stb[1]), .ab_wre(ab_wre[1]), .ab_dto(ab_dto[1]),
        .ab_dti(ab_dti[1]), .ab_ack(ab_ack[1]), .wp_err(wp_err[1]));

    dcpu16_mem_resp #(.AW(12), .WAIT(5)) u_w5 (
        .clk(clk), .rst(rst[2]),
        .fs_adr(fs_adr[2]), .fs_stb(fs_stb[2]), .fs_wre(fs_wre[2]), .fs_dto(fs_dto[2]),
        .fs_dti(fs_dti[2]), .fs_ack(fs_ack[2]),
        .ab_adr(ab_adr[2]), .ab_stb(ab_stb[2]), .ab_wre(ab_wre[2]), .ab_dto(ab_dto[2]),
        .ab_dti(ab_dti[2]), .ab_ack(ab_ack[2]), .wp_err(wp_err[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transfer on instance k; checks latency, no ack on the other port, and a one-cycle ack.
    task automatic xfer(input int k, input bit ab, input bit wr, input logic [15:0] adr,
                        input logic [15:0] dto, input int lat, input string tag,
                        output logic [15:0] rd);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        if (ab) begin
            ab_adr[k] = adr; ab_wre[k] = wr; ab_dto[k] = dto; ab_stb[k] = 1'b1;
        end else begin
            fs_adr[k] = adr; fs_wre[k] = wr; fs_dto[k] = dto; fs_stb[k] = 1'b1;
        end
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            got = ab ? ab_ack[k] : fs_ack[k];
        end
        if (ab) ab_stb[k] = 1'b0; else fs_stb[k] = 1'b0;
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_xack"}, {31'd0, (ab ? fs_ack[k] : ab_ack[k])}, 32'd0);
        rd = ab ? ab_dti[k] : fs_dti[k];
        @(posedge clk); #1;
        chk({tag, "_ack1"}, {31'd0, (ab ? ab_ack[k] : fs_ack[k])}, 32'd0);
    endtask

    initial begin
        logic [15:0] rd;
        int          ack_cyc [4];
        bit          ack_ab  [4];
        int          nack, fs_n, ab_n, overlap, cnt, ackc;
        logic [15:0] rr_fs_rd, rr_ab_rd;

        rst = 3'b111;
        fs_stb = 3'b000; ab_stb = 3'b000; fs_wre = 3'b000; ab_wre = 3'b000;
        fs_adr = '0; fs_dto = '0; ab_adr = '0; ab_dto = '0;
        repeat (3) @(posedge clk);
        #1 rst = 3'b000;

        // reset values
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_fs_ack%0d", k), {31'd0, fs_ack[k]}, 32'd0);
            chk($sformatf("rst_ab_ack%0d", k), {31'd0, ab_ack[k]}, 32'd0);
            chk($sformatf("rst_fs_dti%0d", k), {16'd0, fs_dti[k]}, 32'h0000);
            chk($sformatf("rst_ab_dti%0d", k), {16'd0, ab_dti[k]}, 32'h0000);
            chk($sformatf("rst_wp%0d", k), {31'd0, wp_err[k]}, 32'd0);
        end

        // round robin from reset: FS first, then strict alternation, 2 cycles apart
        for (int i = 0; i < 4; i++) begin ack_cyc[i] = -1; ack_ab[i] = 1'b0; end
        nack = 0; fs_n = 0; ab_n = 0; overlap = 0;
        rr_fs_rd = 16'h0; rr_ab_rd = 16'h0;
        fs_adr[0] = 16'h0210; fs_wre[0] = 1'b1; fs_dto[0] = 16'h1111; fs_stb[0] = 1'b1;
        ab_adr[0] = 16'h0220; ab_wre[0] = 1'b1; ab_dto[0] = 16'h2222; ab_stb[0] = 1'b1;
        for (int c = 1; c <= 20 && nack < 4; c++) begin
            @(posedge clk); #1;
            if (fs_ack[0] && ab_ack[0]) overlap++;
            if (fs_ack[0]) begin
                if (nack < 4) begin ack_cyc[nack] = c; ack_ab[nack] = 1'b0; end
                nack++; fs_n++;
                if (fs_n == 1) begin fs_wre[0] = 1'b0; fs_adr[0] = 16'h0220; end
                else begin rr_fs_rd = fs_dti[0]; fs_stb[0] = 1'b0; end
            end
            if (ab_ack[0]) begin
                if (nack < 4) begin ack_cyc[nack] = c; ack_ab[nack] = 1'b1; end
                nack++; ab_n++;
                if (ab_n == 1) begin ab_wre[0] = 1'b0; ab_adr[0] = 16'h0210; end
                else begin rr_ab_rd = ab_dti[0]; ab_stb[0] = 1'b0; end
            end
        end
        fs_stb[0] = 1'b0; ab_stb[0] = 1'b0;
        chk("rr_overlap", 32'(overlap), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_port%0d", i), {31'd0, ack_ab[i]}, 32'(i % 2));
            chk($sformatf("rr_cyc%0d", i), 32'(ack_cyc[i]), 32'(2 * i + 1));
        end
        chk("rr_fs_rd", {16'd0, rr_fs_rd}, 32'h2222);
        chk("rr_ab_rd", {16'd0, rr_ab_rd}, 32'h1111);
        @(posedge clk); #1;

        // preload then FS read, WAIT=0
        xfer(0, 1'b0, 1'b1, T1_ADR, 16'h7C01, 1, "t1_wr", rd);
        xfer(0, 1'b0, 1'b0, T1_ADR, 16'h0000, 1, "t1_rd", rd);
        chk("t1_data", {16'd0, rd}, 32'h7C01);

        // stb held through the ack cycle with changed data: one ack, no second write
        cnt = 0; ackc = 0;
        fs_adr[0] = 16'h0240; fs_wre[0] = 1'b1; fs_dto[0] = 16'h5A5A; fs_stb[0] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (fs_ack[0]) begin cnt++; ackc = c; fs_dto[0] = 16'hDEAD; end
            if (ackc != 0 && c == ackc + 1) fs_stb[0] = 1'b0;
        end
        fs_stb[0] = 1'b0;
        chk("hold_acks", 32'(cnt), 32'd1);
        xfer(0, 1'b0, 1'b0, 16'h0240, 16'h0000, 1, "hold_rd", rd);
        chk("hold_data", {16'd0, rd}, 32'h5A5A);

        // address wrap and aliasing; writes and other-port reads leave fs_dti alone
        xfer(0, 1'b0, 1'b1, 16'hFFFF, 16'hCAFE, 1, "wrap_wr", rd);
        chk("wrap_fsdti_w", {16'd0, fs_dti[0]}, 32'h5A5A);
        xfer(0, 1'b1, 1'b0, 16'h0FFF, 16'h0000, 1, "wrap_rd", rd);
        chk("wrap_data", {16'd0, rd}, 32'hCAFE);
        chk("wrap_fsdti_r", {16'd0, fs_dti[0]}, 32'h5A5A);
        xfer(0, 1'b1, 1'b1, 16'h1000, 16'h0BAD, 1, "alias_wr", rd);
        xfer(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, "alias_rd", rd);
        chk("alias_data", {16'd0, rd}, 32'h0BAD);

        // WAIT=3: ack 4 cycles after stb
        xfer(1, 1'b1, 1'b1, 16'h1000, 16'hBEEF, 4, "w3_wr", rd);
        chk("w3_abdti_w", {16'd0, ab_dti[1]}, 32'h0000);
        xfer(1, 1'b1, 1'b0, 16'h1000, 16'h0000, 4, "w3_rd", rd);
        chk("w3_data", {16'd0, rd}, 32'hBEEF);
        chk("w3_fsdti", {16'd0, fs_dti[1]}, 32'h0000);

        // WAIT=5: reset during the wait drops the pending write
        xfer(2, 1'b0, 1'b1, 16'h0300, 16'h5555, 6, "w5_pre", rd);
        cnt = 0;
        fs_adr[2] = 16'h0300; fs_wre[2] = 1'b1; fs_dto[2] = 16'hAAAA; fs_stb[2] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (fs_ack[2] || ab_ack[2]) cnt++;
            if (c == 3) begin rst[2] = 1'b1; fs_stb[2] = 1'b0; end
            if (c == 4) rst[2] = 1'b0;
        end
        chk("w5_rst_acks", 32'(cnt), 32'd0);
        xfer(2, 1'b0, 1'b0, 16'h0300, 16'h0000, 6, "w5_rd", rd);
        chk("w5_data", {16'd0, rd}, 32'h5555);

`ifdef DCPU16_MEM_WPROT_EN
        // protected write is acked but ignored; alias above PTOP is writable
        xfer(0, 1'b0, 1'b1, 16'h1010, 16'h0F0F, 1, "wp_pre", rd);
        chk("wp_clear", {31'd0, wp_err[0]}, 32'd0);
        xfer(0, 1'b0, 1'b1, 16'h0010, 16'h1234, 1, "wp_wr", rd);
        chk("wp_set", {31'd0, wp_err[0]}, 32'd1);
        xfer(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1, "wp_rd", rd);
        chk("wp_data", {16'd0, rd}, 32'h0F0F);
        xfer(0, 1'b1, 1'b1, 16'h0200, 16'h4321, 1, "wp_ok_wr", rd);
        xfer(0, 1'b0, 1'b0, 16'h0200, 16'h0000, 1, "wp_ok_rd", rd);
        chk("wp_ok_data", {16'd0, rd}, 32'h4321);
        chk("wp_sticky", {31'd0, wp_err[0]}, 32'd1);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        chk("wp_rst", {31'd0, wp_err[0]}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
